// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute control FSM for the accumulator datapath.
// Optional memory-handshake watchdog enabled by defining WAIT_TIMEOUT_EN.
module control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       control_reset_n,
  input  logic [3:0] opcode,
  input  logic       flag_Z,
  input  logic       flag_N,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       pc_inc,
  output logic       pc_wr,
  output logic       acc_wr,
  output logic [2:0] alu_op,
  output logic       alu_b_sel,
  output logic       status_wr,
  output logic       status_reset,
  output logic       branch_taken,
  output logic       halted,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    EXEC   = 3'd5,
    BRANCH = 3'd6,
    HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_BNE = 4'hA;
  localparam logic [3:0] OP_BLT = 4'hB;
  localparam logic [3:0] OP_BGE = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b100;
  localparam logic [2:0] ALU_NOT    = 3'b101;

  state_t state;
  state_t state_nxt;
  logic   timeout_c;

`ifdef WAIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting_c;

  assign waiting_c = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;
  // Fires on the cycle whose stall would bring the count up to TIMEOUT_CYCLES.
  assign timeout_c = waiting_c && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Any state change clears the count, so each access starts from zero.
  always_ff @(posedge clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (waiting_c) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky until reset.
  always_ff @(posedge clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      bus_error <= 1'b0;
    end else if (timeout_c) begin
      bus_error <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
  assign bus_error      = 1'b0;
`endif

  always_ff @(posedge clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      state <= START;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore/Mealy strobe decode.
  always_comb begin
    state_nxt    = state;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_wr        = 1'b0;
    pc_inc       = 1'b0;
    pc_wr        = 1'b0;
    acc_wr       = 1'b0;
    alu_op       = ALU_PASS_B;
    alu_b_sel    = 1'b0;
    status_wr    = 1'b0;
    status_reset = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;

    case (state)
      START: begin
        status_reset = 1'b1;
        state_nxt    = FETCH;
      end

      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_c) begin
          state_nxt = HALT;
        end
      end

      DECODE: begin
        case (opcode)
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = MEM_RD;
          OP_ST:                                state_nxt = MEM_WR;
          OP_NOT, OP_LDI:                       state_nxt = EXEC;
          OP_JMP:                               state_nxt = BRANCH;
          OP_BEQ:                               state_nxt = flag_Z ? BRANCH : FETCH;
          OP_BNE:                               state_nxt = flag_Z ? FETCH : BRANCH;
          OP_BLT:                               state_nxt = flag_N ? BRANCH : FETCH;
          OP_BGE:                               state_nxt = flag_N ? FETCH : BRANCH;
          OP_HLT:                               state_nxt = HALT;
          default:                              state_nxt = FETCH;
        endcase
      end

      MEM_RD: begin
        mem_rd    = 1'b1;
        alu_b_sel = 1'b0;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          OP_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_PASS_B;
        endcase
        if (mem_ready) begin
          acc_wr    = 1'b1;
          status_wr = 1'b1;
          state_nxt = FETCH;
        end else if (timeout_c) begin
          state_nxt = HALT;
        end
      end

      MEM_WR: begin
        mem_wr = 1'b1;
        if (mem_ready) begin
          state_nxt = FETCH;
        end else if (timeout_c) begin
          state_nxt = HALT;
        end
      end

      EXEC: begin
        acc_wr    = 1'b1;
        status_wr = 1'b1;
        if (opcode == OP_LDI) begin
          alu_op    = ALU_PASS_B;
          alu_b_sel = 1'b1;
        end else begin
          alu_op    = ALU_NOT;
          alu_b_sel = 1'b0;
        end
        state_nxt = FETCH;
      end

      BRANCH: begin
        pc_wr        = 1'b1;
        branch_taken = 1'b1;
        state_nxt    = FETCH;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = START;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; outputs are packed into one
// vector and compared against hand-built patterns after each clock edge.
module tb_control_unit;

  logic       clock;
  logic       control_reset_n;
  logic [3:0] opcode;
  logic       flag_Z;
  logic       flag_N;
  logic       mem_ready;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_wr;
  logic       pc_inc;
  logic       pc_wr;
  logic       acc_wr;
  logic [2:0] alu_op;
  logic       alu_b_sel;
  logic       status_wr;
  logic       status_reset;
  logic       branch_taken;
  logic       halted;
  logic       bus_error;

  int n_checks = 0;
  int n_pass   = 0;

  // Output vector layout: {mem_rd, mem_wr, ir_wr, pc_inc, pc_wr, acc_wr,
  //                        alu_op[2:0], alu_b_sel, status_wr, status_reset,
  //                        branch_taken, halted, bus_error}
  localparam logic [14:0] B_RD   = 15'h4000;
  localparam logic [14:0] B_WR   = 15'h2000;
  localparam logic [14:0] B_IRW  = 15'h1000;
  localparam logic [14:0] B_PCI  = 15'h0800;
  localparam logic [14:0] B_PCW  = 15'h0400;
  localparam logic [14:0] B_ACC  = 15'h0200;
  localparam logic [14:0] A_ADD  = 15'h0040;
  localparam logic [14:0] A_SUB  = 15'h0080;
  localparam logic [14:0] A_AND  = 15'h00C0;
  localparam logic [14:0] A_OR   = 15'h0100;
  localparam logic [14:0] A_NOT  = 15'h0140;
  localparam logic [14:0] B_BSEL = 15'h0020;
  localparam logic [14:0] B_SW   = 15'h0010;
  localparam logic [14:0] B_SR   = 15'h0008;
  localparam logic [14:0] B_BT   = 15'h0004;
  localparam logic [14:0] B_HLT  = 15'h0002;
  localparam logic [14:0] B_BE   = 15'h0001;

  localparam logic [14:0] P_IDLE      = 15'h0000;
  localparam logic [14:0] P_START     = B_SR;
  localparam logic [14:0] P_FETCH_W   = B_RD;
  localparam logic [14:0] P_FETCH_RDY = B_RD | B_IRW | B_PCI;
  localparam logic [14:0] P_BRANCH    = B_PCW | B_BT;
  localparam logic [14:0] P_HALT      = B_HLT;

  control_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock           (clock),
    .control_reset_n (control_reset_n),
    .opcode          (opcode),
    .flag_Z          (flag_Z),
    .flag_N          (flag_N),
    .mem_ready       (mem_ready),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .ir_wr           (ir_wr),
    .pc_inc          (pc_inc),
    .pc_wr           (pc_wr),
    .acc_wr          (acc_wr),
    .alu_op          (alu_op),
    .alu_b_sel       (alu_b_sel),
    .status_wr       (status_wr),
    .status_reset    (status_reset),
    .branch_taken    (branch_taken),
    .halted          (halted),
    .bus_error       (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] observe();
    return {mem_rd, mem_wr, ir_wr, pc_inc, pc_wr, acc_wr, alu_op, alu_b_sel,
            status_wr, status_reset, branch_taken, halted, bus_error};
  endfunction

  // Advance one clock, then drive mem_ready for the new cycle and settle.
  task automatic tick(input logic rdy);
    @(posedge clock);
    #2;
    mem_ready = rdy;
    #1;
  endtask

  // Leaves the FSM in START, 3 time units after an edge.
  task automatic do_reset();
    @(posedge clock);
    #2;
    control_reset_n = 1'b0;
    mem_ready       = 1'b1;
    #10;
    control_reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp_q [7];
    exp_q = '{P_START, P_FETCH_RDY, P_IDLE, P_FETCH_RDY, P_IDLE, P_FETCH_RDY, P_IDLE};
    #3;
    n_checks++;
    if (observe() !== P_START) $display("FAIL in_reset: got %b want %b", observe(), P_START);
    else n_pass++;
    do_reset();
    opcode = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) opcode = 4'hE;
      if (i > 0) tick(1'b1);
      n_checks++;
      if (observe() !== exp_q[i])
        $display("FAIL nop_loop[%0d]: got %b want %b", i, observe(), exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mem_rd_wait();
    logic        rdy_q [7];
    logic [14:0] exp_q [7];
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q = '{P_FETCH_RDY, P_IDLE, B_RD | A_ADD, B_RD | A_ADD, B_RD | A_ADD,
              B_RD | A_ADD | B_ACC | B_SW, P_FETCH_RDY};
    do_reset();
    opcode = 4'h3;
    for (int i = 0; i < 7; i++) begin
      tick(rdy_q[i]);
      n_checks++;
      if (observe() !== exp_q[i])
        $display("FAIL add_wait[%0d]: got %b want %b", i, observe(), exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  op_q  [8];
    logic [14:0] exp_q [8];
    op_q  = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hD, 4'h2};
    exp_q = '{B_RD | B_ACC | B_SW,
              B_RD | A_ADD | B_ACC | B_SW,
              B_RD | A_SUB | B_ACC | B_SW,
              B_RD | A_AND | B_ACC | B_SW,
              B_RD | A_OR  | B_ACC | B_SW,
              A_NOT | B_ACC | B_SW,
              B_BSEL | B_ACC | B_SW,
              B_WR};
    do_reset();
    tick(1'b1);
    for (int i = 0; i < 8; i++) begin
      opcode = op_q[i];
      tick(1'b1);
      n_checks++;
      if (observe() !== P_IDLE)
        $display("FAIL op%h_decode: got %b want %b", op_q[i], observe(), P_IDLE);
      else n_pass++;
      tick(1'b1);
      n_checks++;
      if (observe() !== exp_q[i])
        $display("FAIL op%h_exec: got %b want %b", op_q[i], observe(), exp_q[i]);
      else n_pass++;
      tick(1'b1);
      n_checks++;
      if (observe() !== P_FETCH_RDY)
        $display("FAIL op%h_refetch: got %b want %b", op_q[i], observe(), P_FETCH_RDY);
      else n_pass++;
    end
  endtask

  task automatic test_store_wait();
    logic        rdy_q [6];
    logic [14:0] exp_q [6];
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q = '{P_FETCH_RDY, P_IDLE, B_WR, B_WR, B_WR, P_FETCH_RDY};
    do_reset();
    opcode = 4'h2;
    for (int i = 0; i < 6; i++) begin
      tick(rdy_q[i]);
      n_checks++;
      if (observe() !== exp_q[i])
        $display("FAIL st_wait[%0d]: got %b want %b", i, observe(), exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    logic [3:0] op_q [10];
    logic       z_q  [10];
    logic       n_q  [10];
    logic       tk_q [10];
    op_q = '{4'h9, 4'h9, 4'hA, 4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'h8, 4'h8};
    z_q  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    n_q  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tk_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      opcode = op_q[i];
      flag_Z = z_q[i];
      flag_N = n_q[i];
      tick(1'b1);
      n_checks++;
      if (observe() !== P_IDLE)
        $display("FAIL br[%0d]_decode: got %b want %b", i, observe(), P_IDLE);
      else n_pass++;
      tick(1'b1);
      n_checks++;
      if (observe() !== (tk_q[i] ? P_BRANCH : P_FETCH_RDY))
        $display("FAIL br[%0d]_op%h_z%0d_n%0d: got %b want %b", i, op_q[i], z_q[i], n_q[i],
                 observe(), tk_q[i] ? P_BRANCH : P_FETCH_RDY);
      else n_pass++;
      if (tk_q[i]) begin
        tick(1'b1);
        n_checks++;
        if (observe() !== P_FETCH_RDY)
          $display("FAIL br[%0d]_refetch: got %b want %b", i, observe(), P_FETCH_RDY);
        else n_pass++;
      end
    end
    flag_Z = 1'b0;
    flag_N = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 4'hF;
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 21; i++) begin
      tick(1'(i % 2));
      opcode = 4'(i);
      n_checks++;
      if (observe() !== P_HALT)
        $display("FAIL halt_hold[%0d]: got %b want %b", i, observe(), P_HALT);
      else n_pass++;
    end
    #2;
    control_reset_n = 1'b0;
    #1;
    n_checks++;
    if (observe() !== P_START) $display("FAIL halt_async_rst: got %b want %b", observe(), P_START);
    else n_pass++;
    @(posedge clock);
    #2;
    control_reset_n = 1'b1;
    mem_ready       = 1'b1;
    #1;
    tick(1'b1);
    n_checks++;
    if (observe() !== P_FETCH_RDY) $display("FAIL halt_restart: got %b want %b", observe(), P_FETCH_RDY);
    else n_pass++;

    // Reset while a memory read is stalled.
    opcode = 4'h1;
    tick(1'b0);
    tick(1'b0);
    n_checks++;
    if (observe() !== B_RD) $display("FAIL ld_stall: got %b want %b", observe(), B_RD);
    else n_pass++;
    #2;
    control_reset_n = 1'b0;
    #1;
    n_checks++;
    if (observe() !== P_START) $display("FAIL ld_async_rst: got %b want %b", observe(), P_START);
    else n_pass++;
    control_reset_n = 1'b1;
  endtask

  task automatic test_timeout();
`ifdef WAIT_TIMEOUT_EN
    logic        rdy_a [6];
    logic [14:0] exp_a [6];
    logic        rdy_b [14];
    logic [14:0] exp_b [14];
    rdy_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_a = '{B_RD, B_RD, B_RD, B_RD, B_HLT | B_BE, B_HLT | B_BE};
    rdy_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0};
    exp_b = '{B_RD, B_RD, B_RD, P_FETCH_RDY, P_IDLE, B_RD, B_RD, B_RD,
              B_RD | B_ACC | B_SW, P_FETCH_RDY, P_IDLE, B_RD, B_RD, B_RD};
    do_reset();
    opcode = 4'h1;
    for (int i = 0; i < 6; i++) begin
      tick(rdy_a[i]);
      n_checks++;
      if (observe() !== exp_a[i])
        $display("FAIL fetch_timeout[%0d]: got %b want %b", i, observe(), exp_a[i]);
      else n_pass++;
    end
    do_reset();
    n_checks++;
    if (observe() !== P_START) $display("FAIL be_cleared: got %b want %b", observe(), P_START);
    else n_pass++;
    for (int i = 0; i < 14; i++) begin
      tick(rdy_b[i]);
      n_checks++;
      if (observe() !== exp_b[i])
        $display("FAIL ready_at_limit[%0d]: got %b want %b", i, observe(), exp_b[i]);
      else n_pass++;
    end
    // Fourth stalled cycle of the MEM_RD above ends in HALT with bus_error.
    tick(1'b0);
    n_checks++;
    if (observe() !== B_RD) $display("FAIL memrd_wait4: got %b want %b", observe(), B_RD);
    else n_pass++;
    tick(1'b0);
    n_checks++;
    if (observe() !== (B_HLT | B_BE))
      $display("FAIL memrd_timeout: got %b want %b", observe(), B_HLT | B_BE);
    else n_pass++;
`else
    do_reset();
    opcode = 4'h0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0);
      n_checks++;
      if (observe() !== P_FETCH_W)
        $display("FAIL fetch_wait_forever[%0d]: got %b want %b", i, observe(), P_FETCH_W);
      else n_pass++;
    end
    tick(1'b1);
    n_checks++;
    if (observe() !== P_FETCH_RDY)
      $display("FAIL fetch_late_ready: got %b want %b", observe(), P_FETCH_RDY);
    else n_pass++;
`endif
  endtask

  initial begin
    control_reset_n = 1'b0;
    opcode          = 4'h0;
    flag_Z          = 1'b0;
    flag_N          = 1'b0;
    mem_ready       = 1'b0;
    test_reset();
    test_mem_rd_wait();
    test_alu_ops();
    test_store_wait();
    test_branch();
    test_halt();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
